// File: rtl/router_output_channel.sv
// Transmit side of a mesh router port: two polarity-indexed virtual channel FIFOs
// filled from the crossbar and drained onto the downstream send/ready link.
module router_output_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_polarity,
  input  logic                    i_data_valid,
  input  logic [DATA_WIDTH-1:0]   i_data_in,
  output logic                    o_buf_ready,
  input  logic                    i_ready_in,
  output logic                    o_send,
  output logic [DATA_WIDTH-1:0]   o_data_out,
  output logic [$clog2(DEPTH):0]  o_vc0_count,
  output logic [$clog2(DEPTH):0]  o_vc1_count
);

  // A single-entry VC still needs a 1-bit pointer; it simply never leaves zero.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]         r_head  [2];
  logic [PW-1:0]         r_tail  [2];
  logic [CW-1:0]         r_count [2];
  logic [DATA_WIDTH-1:0] r_mem   [2][DEPTH];
  logic                  r_send;
  logic [DATA_WIDTH-1:0] r_dataOut;

  logic                  w_wrVc;
  logic                  w_rdVc;
  logic                  w_doWrite;
  logic                  w_doRead;
  logic [DATA_WIDTH-1:0] w_rdData;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Writer always targets VC[polarity], the link always drains the other one.
  assign w_wrVc      = i_polarity;
  assign w_rdVc      = ~i_polarity;
  assign o_buf_ready = !reset && (r_count[w_wrVc] != CW'(DEPTH));
  assign w_doWrite   = i_data_valid && o_buf_ready;
  assign w_doRead    = (r_count[w_rdVc] != '0) && i_ready_in;
  assign w_rdData    = r_mem[w_rdVc][r_head[w_rdVc]];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < 2; v++) begin
        r_head[v]  <= '0;
        r_tail[v]  <= '0;
        r_count[v] <= '0;
      end
      r_send    <= 1'b0;
      r_dataOut <= '0;
    end else begin
      if (w_doWrite) begin
        r_tail[w_wrVc]  <= nextPtr(r_tail[w_wrVc]);
        r_count[w_wrVc] <= r_count[w_wrVc] + CW'(1);
      end
      if (w_doRead) begin
        r_head[w_rdVc]  <= nextPtr(r_head[w_rdVc]);
        r_count[w_rdVc] <= r_count[w_rdVc] - CW'(1);
        r_send          <= 1'b1;
        r_dataOut       <= w_rdData;
      end else begin
        r_send    <= 1'b0;
        r_dataOut <= '0;
      end
    end
  end

  // Payload storage carries no reset; stale entries are unreachable once counts clear.
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      r_mem[w_wrVc][r_tail[w_wrVc]] <= i_data_in;
    end
  end

  assign o_send      = r_send;
  assign o_data_out  = r_dataOut;
  assign o_vc0_count = r_count[0];
  assign o_vc1_count = r_count[1];

endmodule

// File: tb/tb_router_output_channel.sv
// Self-checking bench for router_output_channel: directed scenarios plus a randomized
// run, all compared against a queue-based model of the two virtual channels.
module tb_router_output_channel;

  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pol;
  logic          valid;
  logic [DW-1:0] din;
  logic          rdy;
  logic          o_buf_ready;
  logic          o_send;
  logic [DW-1:0] o_data_out;
  logic [CW-1:0] o_vc0_count;
  logic [CW-1:0] o_vc1_count;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];
  logic          expSend;
  logic [DW-1:0] expData;
  logic          expPreReady;
  logic          obsPreReady;

  router_output_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_polarity(pol), .i_data_valid(valid),
    .i_data_in(din), .o_buf_ready(o_buf_ready), .i_ready_in(rdy),
    .o_send(o_send), .o_data_out(o_data_out),
    .o_vc0_count(o_vc0_count), .o_vc1_count(o_vc1_count)
  );

  always #5 clk = ~clk;

  function automatic int occ(input logic vc);
    return vc ? mq1.size() : mq0.size();
  endfunction

  function automatic logic [DW-1:0] rndPkt();
    logic [DW-1:0] v;
    v = {$urandom, $urandom};
    if (v == '0) v = 64'h1;
    return v;
  endfunction

  // Advance one clock: sample buf_ready mid-cycle, apply the model at the edge, toggle polarity.
  task automatic tick();
    #1;
    obsPreReady = o_buf_ready;
    expPreReady = !reset && (occ(pol) != DEPTH);
    @(posedge clk);
    expSend = 1'b0;
    expData = '0;
    if (reset) begin
      mq0.delete();
      mq1.delete();
    end else begin
      if (valid && expPreReady) begin
        if (pol) mq1.push_back(din);
        else     mq0.push_back(din);
      end
      if (rdy && occ(!pol) != 0) begin
        expSend = 1'b1;
        expData = pol ? mq0.pop_front() : mq1.pop_front();
      end
    end
    #1;
    pol = ~pol;
  endtask

  task automatic alignTo(input logic p);
    valid = 1'b0;
    if (pol !== p) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; rdy = 1'b1; din = '0; pol = 1'b0;
    repeat (2) tick();
    checks++;
    if (obsPreReady !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_buf_ready got=%b exp=0", obsPreReady);
    end
    checks++;
    if (o_send !== 1'b0 || o_data_out !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs send=%b data=%h exp send=0 data=0", o_send, o_data_out);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obsPreReady !== 1'b1) begin
        failures++; $display("[TB] FAIL idle_buf_ready cyc=%0d got=%b exp=1", i, obsPreReady);
      end
      checks++;
      if (o_send !== 1'b0 || o_data_out !== '0 || o_vc0_count !== '0 || o_vc1_count !== '0) begin
        failures++;
        $display("[TB] FAIL idle_state cyc=%0d send=%b data=%h c0=%0d c1=%0d exp all 0",
                 i, o_send, o_data_out, o_vc0_count, o_vc1_count);
      end
    end
  endtask

  task automatic test_single();
    alignTo(1'b0);
    rdy = 1'b1; valid = 1'b1; din = 64'hA5;
    tick();
    valid = 1'b0;
    checks++;
    if (o_vc0_count !== CW'(1) || o_send !== 1'b0) begin
      failures++; $display("[TB] FAIL single_accept c0=%0d send=%b exp c0=1 send=0", o_vc0_count, o_send);
    end
    tick();
    checks++;
    if (o_send !== 1'b1 || o_data_out !== 64'hA5 || o_vc0_count !== '0) begin
      failures++;
      $display("[TB] FAIL single_send send=%b data=%h c0=%0d exp send=1 data=a5 c0=0", o_send, o_data_out, o_vc0_count);
    end
    tick();
    checks++;
    if (o_send !== 1'b0 || o_data_out !== '0) begin
      failures++; $display("[TB] FAIL single_pulse send=%b data=%h exp send=0 data=0", o_send, o_data_out);
    end
  endtask

  task automatic test_alternating();
    alignTo(1'b0);
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid = (i < 4);
      din   = DW'(i + 1);
      tick();
      checks++;
      if (o_send !== expSend || o_data_out !== expData) begin
        failures++;
        $display("[TB] FAIL alt_model cyc=%0d send=%b data=%h exp send=%b data=%h", i, o_send, o_data_out, expSend, expData);
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (o_send !== 1'b1 || o_data_out !== DW'(i)) begin
          failures++;
          $display("[TB] FAIL alt_order cyc=%0d send=%b data=%h exp send=1 data=%h", i, o_send, o_data_out, DW'(i));
        end
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_fill();
    logic [DW-1:0] pk[5];
    int   nSent;
    logic prevSend;
    for (int i = 0; i < 5; i++) pk[i] = rndPkt();
    rdy = 1'b0;
    alignTo(1'b0);
    for (int i = 0; i < 6; i++) begin
      valid = (i % 2 == 0);
      din   = pk[i / 2];
      tick();
      if (i == 4) begin
        checks++;
        if (obsPreReady !== 1'b0) begin
          failures++; $display("[TB] FAIL fill_full_ready got=%b exp=0", obsPreReady);
        end
      end
    end
    valid = 1'b0;
    checks++;
    if (o_vc0_count !== CW'(DEPTH)) begin
      failures++; $display("[TB] FAIL fill_count got=%0d exp=%0d", o_vc0_count, DEPTH);
    end
    for (int round = 0; round < 2; round++) begin
      alignTo(1'b0);
      rdy = 1'b1; nSent = 0; prevSend = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        checks++;
        if (o_send !== expSend || o_data_out !== expData || o_vc0_count !== CW'(mq0.size())) begin
          failures++;
          $display("[TB] FAIL fill_drain r=%0d cyc=%0d send=%b data=%h c0=%0d exp send=%b data=%h c0=%0d",
                   round, i, o_send, o_data_out, o_vc0_count, expSend, expData, mq0.size());
        end
        checks++;
        if (o_send === 1'b1 && prevSend === 1'b1) begin
          failures++; $display("[TB] FAIL fill_spacing r=%0d cyc=%0d got=consecutive exp=gap", round, i);
        end
        if (o_send === 1'b1) begin
          checks++;
          if (nSent < 2 && o_data_out !== pk[round * 3 + nSent]) begin
            failures++;
            $display("[TB] FAIL fill_order r=%0d n=%0d got=%h exp=%h", round, nSent, o_data_out, pk[round * 3 + nSent]);
          end
          nSent++;
        end
        prevSend = o_send;
      end
      checks++;
      if (nSent != 2) begin
        failures++; $display("[TB] FAIL fill_send_count r=%0d got=%0d exp=2", round, nSent);
      end
      if (round == 0) begin
        rdy = 1'b0;
        alignTo(1'b0);
        for (int i = 0; i < 4; i++) begin
          valid = (i % 2 == 0);
          din   = pk[3 + i / 2];
          tick();
        end
        valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    rdy = 1'b0;
    alignTo(1'b1);
    valid = 1'b1; din = 64'hBEEF;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (o_send !== 1'b0 || o_vc1_count !== CW'(1)) begin
        failures++; $display("[TB] FAIL bp_hold cyc=%0d send=%b c1=%0d exp send=0 c1=1", i, o_send, o_vc1_count);
      end
    end
    alignTo(1'b0);
    rdy = 1'b1;
    tick();
    checks++;
    if (o_send !== 1'b1 || o_data_out !== 64'hBEEF || o_vc1_count !== '0) begin
      failures++;
      $display("[TB] FAIL bp_release send=%b data=%h c1=%0d exp send=1 data=beef c1=0", o_send, o_data_out, o_vc1_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    alignTo(1'b0);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; din = rndPkt();
      tick();
    end
    valid = 1'b0;
    checks++;
    if (o_vc0_count !== CW'(DEPTH) || o_vc1_count !== CW'(DEPTH)) begin
      failures++; $display("[TB] FAIL mid_full c0=%0d c1=%0d exp both %0d", o_vc0_count, o_vc1_count, DEPTH);
    end
    reset = 1'b1; rdy = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (o_vc0_count !== '0 || o_vc1_count !== '0 || o_send !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset c0=%0d c1=%0d send=%b exp all 0", o_vc0_count, o_vc1_count, o_send);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (o_send !== 1'b0 || o_data_out !== '0) begin
        failures++; $display("[TB] FAIL mid_stale cyc=%0d send=%b data=%h exp send=0 data=0", i, o_send, o_data_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 99) < 60);
      rdy   = ($urandom_range(0, 99) < 55);
      reset = ($urandom_range(0, 99) < 2);
      din   = rndPkt();
      tick();
      reset = 1'b0;
      checks++;
      if (obsPreReady !== expPreReady) begin
        failures++; $display("[TB] FAIL rand_buf_ready cyc=%0d got=%b exp=%b", i, obsPreReady, expPreReady);
      end
      checks++;
      if (o_send !== expSend || o_data_out !== expData) begin
        failures++;
        $display("[TB] FAIL rand_send cyc=%0d send=%b data=%h exp send=%b data=%h", i, o_send, o_data_out, expSend, expData);
      end
      checks++;
      if (o_vc0_count !== CW'(mq0.size()) || o_vc1_count !== CW'(mq1.size())) begin
        failures++;
        $display("[TB] FAIL rand_counts cyc=%0d c0=%0d c1=%0d exp c0=%0d c1=%0d",
                 i, o_vc0_count, o_vc1_count, mq0.size(), mq1.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternating();
    test_fill();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
